// File: rtl/imem_prog_loader_pkg.sv
// Shared constants for the MIPS program loader and control decoder: op codes,
// opcode/funct fields, loader FSM state codes and word-packing helpers.
package imem_prog_loader_pkg;

  typedef enum logic [4:0] {
    OP_ADDU  = 5'd0,
    OP_SUBU  = 5'd1,
    OP_ADD   = 5'd2,
    OP_AND   = 5'd3,
    OP_OR    = 5'd4,
    OP_SLT   = 5'd5,
    OP_SLL   = 5'd6,
    OP_JR    = 5'd7,
    OP_ADDI  = 5'd8,
    OP_ADDIU = 5'd9,
    OP_ANDI  = 5'd10,
    OP_ORI   = 5'd11,
    OP_LUI   = 5'd12,
    OP_SW    = 5'd13,
    OP_LW    = 5'd14,
    OP_J     = 5'd15,
    OP_JAL   = 5'd16,
    OP_BEQ   = 5'd17
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] shamt,
                                         input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational encoder: symbolic op plus fields -> 32-bit MIPS word.
// legal drops for op codes outside the table; word is then zero.
module mips_instr_pack
  import imem_prog_loader_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word  = 32'h0000_0000;
    legal = 1'b1;
    case (op)
      OP_ADDU:  word = r_word(rs, rt, rd, 5'd0, FN_ADDU);
      OP_SUBU:  word = r_word(rs, rt, rd, 5'd0, FN_SUBU);
      OP_ADD:   word = r_word(rs, rt, rd, 5'd0, FN_ADD);
      OP_AND:   word = r_word(rs, rt, rd, 5'd0, FN_AND);
      OP_OR:    word = r_word(rs, rt, rd, 5'd0, FN_OR);
      OP_SLT:   word = r_word(rs, rt, rd, 5'd0, FN_SLT);
      OP_SLL:   word = r_word(5'd0, rt, rd, shamt, FN_SLL);
      OP_JR:    word = r_word(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      OP_ADDI:  word = i_word(OPC_ADDI, rs, rt, imm);
      OP_ADDIU: word = i_word(OPC_ADDIU, rs, rt, imm);
      OP_ANDI:  word = i_word(OPC_ANDI, rs, rt, imm);
      OP_ORI:   word = i_word(OPC_ORI, rs, rt, imm);
      OP_LUI:   word = i_word(OPC_LUI, 5'd0, rt, imm);
      OP_SW:    word = i_word(OPC_SW, rs, rt, imm);
      OP_LW:    word = i_word(OPC_LW, rs, rt, imm);
      OP_BEQ:   word = i_word(OPC_BEQ, rs, rt, imm);
      OP_J:     word = {OPC_J, target};
      OP_JAL:   word = {OPC_JAL, target};
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/imem_prog_loader.sv
// Streams encoded ops into instruction memory from word 0 and releases the
// CPU (cpu_run) only after a program has loaded without errors.
module imem_prog_loader
  import imem_prog_loader_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              err_op,
  output logic              err_ovf
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_op_q, err_op_d;
  logic              err_ovf_q, err_ovf_d;
  logic              cpu_run_q, cpu_run_d;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        restart;

  mips_instr_pack u_pack (
    .op     (in_op),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .shamt  (in_shamt),
    .imm    (in_imm),
    .target (in_target),
    .word   (enc_word),
    .legal  (enc_legal)
  );

  assign restart = start && (state_q != ST_LOAD);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_op_d  = err_op_q;
    err_ovf_d = err_ovf_q;
    cpu_run_d = 1'b0;
    if (restart) begin
      state_d   = ST_LOAD;
      ptr_d     = '0;
      err_op_d  = 1'b0;
      err_ovf_d = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_valid) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            // Unknown ops still occupy a slot (as a NOP) so later words keep their addresses.
            wdata_d = enc_legal ? enc_word : 32'h0000_0000;
            if (!enc_legal) err_op_d = 1'b1;
            if (in_last) begin
              state_d = ST_DONE;
            end else if (ptr_q == LAST_ADDR) begin
              state_d   = ST_ERROR;
              err_ovf_d = 1'b1;
            end else begin
              ptr_d = ptr_q + ADDR_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (err_op_q) state_d = ST_ERROR;
          else          cpu_run_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'h0000_0000;
      err_op_q  <= 1'b0;
      err_ovf_q <= 1'b0;
      cpu_run_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_op_q  <= err_op_d;
      err_ovf_q <= err_ovf_d;
      cpu_run_q <= cpu_run_d;
    end
  end

  // Reset also suppresses a write already sitting in the output register.
  assign imem_we    = we_q & ~reset;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign in_ready   = (state_q == ST_LOAD);
  assign cpu_run    = cpu_run_q;
  assign err_op     = err_op_q;
  assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_imem_prog_loader.sv
// Self-checking bench for imem_prog_loader (DEPTH=4): a load-session model
// checked every cycle, plus literal instruction words and flag values.
module tb_imem_prog_loader;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    in_op = 5'd0;
  logic [4:0]    in_rs = 5'd0;
  logic [4:0]    in_rt = 5'd0;
  logic [4:0]    in_rd = 5'd0;
  logic [4:0]    in_shamt = 5'd0;
  logic [15:0]   in_imm = 16'd0;
  logic [25:0]   in_target = 26'd0;
  logic          in_last = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_run;
  logic          err_op;
  logic          err_ovf;

  imem_prog_loader #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_shamt   (in_shamt),
    .in_imm     (in_imm),
    .in_target  (in_target),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .err_op     (err_op),
    .err_ovf    (err_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Reference encoder written straight from the instruction tables.
  function automatic logic [32:0] ref_enc(input logic [4:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh, input logic [15:0] imm,
                                          input logic [25:0] tgt);
    case (op)
      5'd0:  return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h21};
      5'd1:  return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h23};
      5'd2:  return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h20};
      5'd3:  return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h24};
      5'd4:  return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h25};
      5'd5:  return {1'b1, 6'h00, rs, rt, rd, 5'd0, 6'h2A};
      5'd6:  return {1'b1, 6'h00, 5'd0, rt, rd, sh, 6'h00};
      5'd7:  return {1'b1, 6'h00, rs, 15'd0, 6'h08};
      5'd8:  return {1'b1, 6'h08, rs, rt, imm};
      5'd9:  return {1'b1, 6'h09, rs, rt, imm};
      5'd10: return {1'b1, 6'h0C, rs, rt, imm};
      5'd11: return {1'b1, 6'h0D, rs, rt, imm};
      5'd12: return {1'b1, 6'h0F, 5'd0, rt, imm};
      5'd13: return {1'b1, 6'h2B, rs, rt, imm};
      5'd14: return {1'b1, 6'h23, rs, rt, imm};
      5'd15: return {1'b1, 6'h02, tgt};
      5'd16: return {1'b1, 6'h03, tgt};
      5'd17: return {1'b1, 6'h04, rs, rt, imm};
      default: return 33'd0;
    endcase
  endfunction

  // Load-session model: a session opens on start while not loading and
  // closes on in_last or when the last word is consumed.
  bit            m_live = 0;
  bit            m_loading = 0;
  bit            m_clean_end = 0;
  bit            m_err_op = 0;
  bit            m_err_ovf = 0;
  int            m_ptr = 0;
  int            m_accepts = 0;
  logic          exp_we = 1'b0;
  logic          exp_run = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [31:0]   exp_wdata = 32'd0;

  initial forever begin
    logic [32:0] e;
    @(posedge clk);
    exp_we = 1'b0;
    if (reset) begin
      m_live = 1;
      m_loading = 0;
      m_clean_end = 0;
      m_err_op = 0;
      m_err_ovf = 0;
      m_ptr = 0;
      exp_run = 1'b0;
      exp_addr = '0;
      exp_wdata = 32'd0;
    end else if (m_loading) begin
      exp_run = 1'b0;
      if (in_valid) begin
        m_accepts++;
        e = ref_enc(in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
        exp_we = 1'b1;
        exp_addr = AW'(m_ptr);
        exp_wdata = e[32] ? e[31:0] : 32'd0;
        if (!e[32]) m_err_op = 1;
        if (in_last) begin
          m_loading = 0;
          m_clean_end = 1;
        end else if (m_ptr == DEPTH - 1) begin
          m_loading = 0;
          m_err_ovf = 1;
        end else begin
          m_ptr++;
        end
      end
    end else begin
      exp_run = m_clean_end && !m_err_op && !start;
      if (start) begin
        m_loading = 1;
        m_clean_end = 0;
        m_ptr = 0;
        m_err_op = 0;
        m_err_ovf = 0;
      end
    end
  end

  logic [31:0] mem_seen [DEPTH];
  int          wr_count = 0;

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      check("imem_we", 32'(imem_we), 32'(exp_we & ~reset));
      if (!reset) begin
        check("in_ready", 32'(in_ready), 32'(m_loading));
        check("cpu_run", 32'(cpu_run), 32'(exp_run));
        check("err_op", 32'(err_op), 32'(m_err_op));
        check("err_ovf", 32'(err_ovf), 32'(m_err_ovf));
        if (exp_we) begin
          check("imem_addr", 32'(imem_addr), 32'(exp_addr));
          check("imem_wdata", imem_wdata, exp_wdata);
        end
      end
    end
    if (imem_we) begin
      mem_seen[imem_addr] = imem_wdata;
      wr_count++;
      $display("t=%0t write @%0d = %h", $time, imem_addr, imem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic last);
    in_valid = 1'b1;
    in_op = op;
    in_rs = rs;
    in_rt = rt;
    in_rd = rd;
    in_shamt = sh;
    in_imm = imm;
    in_target = tgt;
    in_last = last;
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic clear_seen();
    for (int i = 0; i < DEPTH; i++) mem_seen[i] = 32'hDEAD_BEEF;
  endtask

  initial begin
    int w0;
    int a0;
    clear_seen();
    repeat (3) tick();
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    tick();

    // Basic two-op program
    pulse_start();
    send(5'd9, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'd0, 1'b0);
    send(5'd0, 5'd8, 5'd9, 5'd10, 5'd0, 16'h0000, 26'd0, 1'b1);
    tick();
    check("t1_word0", mem_seen[0], 32'h2408_0005);
    check("t1_word1", mem_seen[1], 32'h0109_5021);
    check("t1_cpu_run", 32'(cpu_run), 32'd1);

    // Restart from DONE; LW / SLL (rs ignored) / J
    clear_seen();
    pulse_start();
    check("t2_run_drop", 32'(cpu_run), 32'd0);
    send(5'd14, 5'd29, 5'd9, 5'd0, 5'd0, 16'h0004, 26'd0, 1'b0);
    send(5'd6, 5'd7, 5'd3, 5'd2, 5'd4, 16'h0000, 26'd0, 1'b0);
    send(5'd15, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h10, 1'b1);
    tick();
    check("t2_lw", mem_seen[0], 32'h8FA9_0004);
    check("t2_sll", mem_seen[1], 32'h0003_1100);
    check("t2_j", mem_seen[2], 32'h0800_0010);
    check("t2_cpu_run", 32'(cpu_run), 32'd1);

    // Valid every other cycle, start pulsed mid-load
    clear_seen();
    pulse_start();
    w0 = wr_count;
    a0 = m_accepts;
    send(5'd12, 5'd5, 5'd1, 5'd0, 5'd0, 16'h1234, 26'd0, 1'b0);
    tick();
    send(5'd7, 5'd31, 5'd4, 5'd5, 5'd3, 16'h0000, 26'd0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    send(5'd11, 5'd2, 5'd3, 5'd0, 5'd0, 16'h00FF, 26'd0, 1'b0);
    tick();
    send(5'd17, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFE, 26'd0, 1'b1);
    tick();
    tick();
    check("t3_writes_vs_accepts", 32'(wr_count - w0), 32'(m_accepts - a0));
    check("t3_write_count", 32'(wr_count - w0), 32'd4);
    check("t3_lui", mem_seen[0], 32'h3C01_1234);
    check("t3_jr", mem_seen[1], 32'h03E0_0008);
    check("t3_ori", mem_seen[2], 32'h3443_00FF);
    check("t3_beq", mem_seen[3], 32'h1022_FFFE);
    check("t3_cpu_run", 32'(cpu_run), 32'd1);

    // Overflow: four ops without last
    clear_seen();
    pulse_start();
    send(5'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'd0, 1'b0);
    send(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'd0, 1'b0);
    send(5'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'd0, 1'b0);
    send(5'd4, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'd0, 1'b0);
    check("t4_err_ovf", 32'(err_ovf), 32'd1);
    check("t4_in_ready", 32'(in_ready), 32'd0);
    send(5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0000, 26'd0, 1'b1);
    check("t4_cpu_run", 32'(cpu_run), 32'd0);
    check("t4_add", mem_seen[0], 32'h0022_1820);
    check("t4_or_at_3", mem_seen[3], 32'h0022_1825);
    pulse_start();
    check("t4_ovf_cleared", 32'(err_ovf), 32'd0);
    send(5'd5, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'd0, 1'b0);
    send(5'd16, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h3FF_FFFF, 1'b1);
    tick();
    check("t4_slt", mem_seen[0], 32'h0022_182A);
    check("t4_jal", mem_seen[1], 32'h0FFF_FFFF);
    check("t4_reload_run", 32'(cpu_run), 32'd1);

    // Illegal op mid-program
    clear_seen();
    pulse_start();
    send(5'd13, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0008, 26'd0, 1'b0);
    send(5'h1F, 5'd1, 5'd1, 5'd1, 5'd1, 16'hFFFF, 26'h3FF_FFFF, 1'b0);
    send(5'd10, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0003, 26'd0, 1'b1);
    tick();
    tick();
    check("t5_sw", mem_seen[0], 32'hAFBF_0008);
    check("t5_nop", mem_seen[1], 32'h0000_0000);
    check("t5_andi", mem_seen[2], 32'h3022_0003);
    check("t5_err_op", 32'(err_op), 32'd1);
    check("t5_cpu_run", 32'(cpu_run), 32'd0);

    // Reset the cycle after an accept
    pulse_start();
    w0 = wr_count;
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'd0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("t6_we_in_reset", 32'(imem_we), 32'd0);
    tick();
    reset = 1'b0;
    check("t6_no_write", 32'(wr_count - w0), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd0);
    check("t6_cpu_run", 32'(cpu_run), 32'd0);
    check("t6_addr", 32'(imem_addr), 32'd0);
    check("t6_wdata", imem_wdata, 32'd0);
    check("t6_err", 32'({err_op, err_ovf}), 32'd0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
